thermo_encoder_pipe: RTL and testbench
======================================

THERMO_ENCODER_PIPE -- requirements
Module: thermo_encoder_pipe

Interface
REQ-001 The block SHALL take parameter N, default 64: thermometer tap count, 8..256, power of two.
REQ-002 The block SHALL take parameter W, default 3: bubble-filter window in taps, 1..8.
REQ-003 The block SHALL take parameter BW, default clog2(N)+1: result width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port thermo_in, input, N bits: raw delay-line taps, tap 0 fills first.
REQ-008 The block SHALL have port hit, input, 1 bit: sample strobe; thermo_in captured at the same edge.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = leading-one encode, 1 = ones-count encode; sampled with hit.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear of sticky flags and hit counter.
REQ-011 The block SHALL have port bin_out, output, BW bits: encoded fine time.
REQ-012 The block SHALL have port valid_out, output, 1 bit: one-cycle qualifier for bin_out, bubble_err and sat.
REQ-013 The block SHALL have port bubble_err, output, 1 bit: result from a non-thermometer vector.
REQ-014 The block SHALL have port sat, output, 1 bit: result where tap N-1 was set.
REQ-015 The block SHALL have port sat_sticky, output, 1 bit: latched OR of sat since last clear/reset.
REQ-016 The block SHALL have port hit_cnt, output, 16 bits: accepted hits, wraps 0xFFFF->0.

Function
REQ-017 Stage 1 SHALL register thermo_in and mode on each edge where hit=1; when hit=0 the stage holds and its valid bit clears.
REQ-018 Stage 2 SHALL form f[k] = OR of raw[k..min(k+W-1,N-1)] for every k, clipped at the top tap.
REQ-019 Stage 2 SHALL flag bubble when f contains any 0 below its highest 1, i.e. a raw gap wider than W-1.
REQ-020 Stage 3 with mode=0 SHALL output (index of highest 1 in f)+1; all-zero gives 0; tap N-1 set gives N.
REQ-021 Stage 3 with mode=1 SHALL output the population count of the raw captured vector, 0..N.
REQ-022 Latency SHALL be exactly 3 edges: hit sampled at edge E0 gives valid_out=1 in the cycle after edge E0+3.
REQ-023 The pipeline SHALL accept hit on every cycle with no stall; back-to-back hits give back-to-back valid_out in order.
REQ-024 Between results, bin_out, bubble_err and sat SHALL hold their last values; only valid_out deasserts.
REQ-025 sat SHALL equal raw[N-1] of the same sample; sat_sticky SHALL set on the valid_out cycle where sat=1.
REQ-026 hit_cnt SHALL increment at the stage-1 capture edge.
REQ-027 When clear and hit occur on the same edge, hit_cnt SHALL become 1.
REQ-028 When clear and a sat result occur on the same edge, sat_sticky SHALL end set.
REQ-029 clear SHALL NOT flush in-flight pipeline samples.
REQ-030 Each mode result SHALL use the mode value captured with its own sample; toggling mode mid-flight SHALL NOT affect earlier samples.

Reset
REQ-031 rst_n=0 SHALL asynchronously force bin_out=0, valid_out=0, bubble_err=0, sat=0, sat_sticky=0, hit_cnt=0, all stage valid bits=0.
REQ-032 Samples in flight when reset is applied SHALL be discarded with no valid_out produced.
REQ-033 The first hit SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (N=64, W=3)
REQ-034 The bench SHALL apply hit with thermo_in=0x0000_0000_0000_00FF, mode=0 -> 3 edges later valid_out=1, bin_out=8, bubble_err=0, sat=0.
REQ-035 The bench SHALL apply thermo_in=0x0000_0000_0000_00F7 (1-tap bubble), mode=0 -> bin_out=8, bubble_err=0; same with mode=1 -> bin_out=7.
REQ-036 The bench SHALL apply thermo_in=0x0000_0000_0000_F00F, mode=0 -> bin_out=16, bubble_err=1.
REQ-037 The bench SHALL apply all-ones then all-zeros on consecutive hits -> consecutive results 64 (sat=1, sat_sticky=1) then 0 (sat=0, sat_sticky stays 1); clear -> sat_sticky=0, hit_cnt=0.
REQ-038 The bench SHALL apply three back-to-back hits then assert rst_n=0 one edge later -> no valid_out occurs and all outputs read reset values.
REQ-039 The bench SHALL preload hit_cnt=0xFFFF via 65535 hits, then apply one hit -> hit_cnt=0x0000; then assert clear with hit on the same edge -> hit_cnt=1.

Source files
------------

// File: rtl/thermo_encoder_pipe.sv
// Pipelined thermometer-to-binary encoder: capture, bubble filter, encode, output.
// Latency 3 edges after the capture edge; accepts a hit every cycle, never stalls.
module thermo_encoder_pipe #(
    parameter int N  = 64,
    parameter int W  = 3,
    parameter int BW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  thermo_in,
    input  logic          hit,
    input  logic          mode,
    input  logic          clear,
    output logic [BW-1:0] bin_out,
    output logic          valid_out,
    output logic          bubble_err,
    output logic          sat,
    output logic          sat_sticky,
    output logic [15:0]   hit_cnt
);

    // Stage 1: raw capture
    logic [N-1:0]  s1_raw_q;
    logic          s1_mode_q;
    logic          s1_vld_q;

    // Stage 2: filtered vector and per-sample flags
    logic [N-1:0]  s2_filt_d, s2_filt_q;
    logic [N-1:0]  s2_raw_q;
    logic          s2_mode_q;
    logic          s2_bub_d, s2_bub_q;
    logic          s2_sat_q;
    logic          s2_vld_q;

    // Stage 3: both encodings, selected at the output
    logic [BW-1:0] s3_lead_d, s3_lead_q;
    logic [BW-1:0] s3_pop_d, s3_pop_q;
    logic          s3_mode_q;
    logic          s3_bub_q;
    logic          s3_sat_q;
    logic          s3_vld_q;

    // Output and status registers
    logic [BW-1:0] bin_d, bin_q;
    logic          bub_d, bub_q;
    logic          sat_d, sat_q;
    logic          sticky_d, sticky_q;
    logic          vld_q;
    logic [15:0]   cnt_d, cnt_q;

    logic [N+W-1:0] raw_ext;
    logic [N-1:0]   filt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_raw_q  <= '0;
            s1_mode_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= hit;
            if (hit) begin
                s1_raw_q  <= thermo_in;
                s1_mode_q <= mode;
            end
        end
    end

    // Zero-extend so window taps past N-1 read as 0 (clipping at the top tap).
    assign raw_ext = {{W{1'b0}}, s1_raw_q};

    always_comb begin
        s2_filt_d = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < W; j++) begin
                s2_filt_d[k] = s2_filt_d[k] | raw_ext[k+j];
            end
        end
    end

    // A clean thermometer code plus one is a power of two, so the AND is zero.
    assign filt_inc = s2_filt_d + N'(1);
    assign s2_bub_d = |(s2_filt_d & filt_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_filt_q <= '0;
            s2_raw_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_bub_q  <= 1'b0;
            s2_sat_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_filt_q <= s2_filt_d;
                s2_raw_q  <= s1_raw_q;
                s2_mode_q <= s1_mode_q;
                s2_bub_q  <= s2_bub_d;
                s2_sat_q  <= s1_raw_q[N-1];
            end
        end
    end

    always_comb begin
        s3_lead_d = '0;
        s3_pop_d  = '0;
        for (int k = 0; k < N; k++) begin
            if (s2_filt_q[k]) begin
                s3_lead_d = BW'(k + 1);
            end
            s3_pop_d = s3_pop_d + BW'(s2_raw_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_lead_q <= '0;
            s3_pop_q  <= '0;
            s3_mode_q <= 1'b0;
            s3_bub_q  <= 1'b0;
            s3_sat_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
        end else begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                s3_lead_q <= s3_lead_d;
                s3_pop_q  <= s3_pop_d;
                s3_mode_q <= s2_mode_q;
                s3_bub_q  <= s2_bub_q;
                s3_sat_q  <= s2_sat_q;
            end
        end
    end

    // Result fields hold between samples; sticky set wins over a same-edge clear.
    always_comb begin
        bin_d = bin_q;
        bub_d = bub_q;
        sat_d = sat_q;
        if (s3_vld_q) begin
            bin_d = s3_mode_q ? s3_pop_q : s3_lead_q;
            bub_d = s3_bub_q;
            sat_d = s3_sat_q;
        end
        sticky_d = (clear ? 1'b0 : sticky_q) | (s3_vld_q & s3_sat_q);
        if (clear) begin
            cnt_d = hit ? 16'd1 : 16'd0;
        end else if (hit) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bub_q    <= 1'b0;
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bin_q    <= bin_d;
            bub_q    <= bub_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
            vld_q    <= s3_vld_q;
            cnt_q    <= cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign valid_out  = vld_q;
    assign bubble_err = bub_q;
    assign sat        = sat_q;
    assign sat_sticky = sticky_q;
    assign hit_cnt    = cnt_q;

endmodule

// File: tb/tb_thermo_encoder_pipe.sv
// Bench for thermo_encoder_pipe: directed vectors, literal expectations and a per-cycle reference model.
module tb_thermo_encoder_pipe;

    localparam int N  = 64;
    localparam int W  = 3;
    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  thermo_in;
    logic          hit;
    logic          mode;
    logic          clear;
    logic [BW-1:0] bin_out;
    logic          valid_out;
    logic          bubble_err;
    logic          sat;
    logic          sat_sticky;
    logic [15:0]   hit_cnt;

    thermo_encoder_pipe #(.N(N), .W(W), .BW(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .thermo_in  (thermo_in),
        .hit        (hit),
        .mode       (mode),
        .clear      (clear),
        .bin_out    (bin_out),
        .valid_out  (valid_out),
        .bubble_err (bubble_err),
        .sat        (sat),
        .sat_sticky (sat_sticky),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leading-one encode equals the top raw one +1, since the window only ORs upward taps.
    function automatic logic [BW-1:0] model_bin(input logic [N-1:0] r, input logic m);
        int top  = 0;
        int ones = 0;
        for (int k = 0; k < N; k++) begin
            if (r[k]) begin
                top = k + 1;
                ones++;
            end
        end
        return m ? BW'(ones) : BW'(top);
    endfunction

    // A bubble is any run of W or more zero taps below the top one.
    function automatic logic model_bub(input logic [N-1:0] r);
        int   top = -1;
        int   run = 0;
        logic b   = 1'b0;
        for (int k = 0; k < N; k++) if (r[k]) top = k;
        for (int k = 0; k < top; k++) begin
            if (!r[k]) begin
                run++;
                if (run >= W) b = 1'b1;
            end else begin
                run = 0;
            end
        end
        return b;
    endfunction

    typedef struct {
        int            cyc;
        logic [BW-1:0] bin;
        logic          bub;
        logic          s;
    } res_t;

    res_t          q[$];
    res_t          r;
    int            cyc      = 0;
    logic [BW-1:0] m_bin    = '0;
    logic          m_vld    = 1'b0;
    logic          m_bub    = 1'b0;
    logic          m_sat    = 1'b0;
    logic          m_sticky = 1'b0;
    logic [15:0]   m_cnt    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cyc = 0; m_bin = '0; m_vld = 0; m_bub = 0; m_sat = 0; m_sticky = 0; m_cnt = '0;
        end else begin
            cyc++;
            m_vld = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                r = q.pop_front();
                m_vld = 1'b1;
                m_bin = r.bin;
                m_bub = r.bub;
                m_sat = r.s;
            end
            m_sticky = (clear ? 1'b0 : m_sticky) | (m_vld & m_sat);
            if (clear)    m_cnt = hit ? 16'd1 : 16'd0;
            else if (hit) m_cnt = m_cnt + 16'd1;
            if (hit) q.push_back('{cyc + 3, model_bin(thermo_in, mode), model_bub(thermo_in), thermo_in[N-1]});
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model valid_out", 32'(valid_out), 32'(m_vld));
            check("model bin_out", 32'(bin_out), 32'(m_bin));
            check("model bubble_err", 32'(bubble_err), 32'(m_bub));
            check("model sat", 32'(sat), 32'(m_sat));
            check("model sat_sticky", 32'(sat_sticky), 32'(m_sticky));
            check("model hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        end
    end

    task automatic do_hit(input logic [N-1:0] v, input logic m);
        hit = 1'b1; thermo_in = v; mode = m;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic lit(input string name, input logic v, input int b, input logic bub, input logic s);
        check({name, " valid"}, 32'(valid_out), 32'(v));
        check({name, " bin"}, 32'(bin_out), 32'(b));
        check({name, " bubble"}, 32'(bubble_err), 32'(bub));
        check({name, " sat"}, 32'(sat), 32'(s));
    endtask

    logic [N-1:0] ones_v;

    initial begin
        ones_v = '1;
        rst_n = 1'b0; hit = 1'b0; mode = 1'b0; clear = 1'b0; thermo_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        lit("reset", 1'b0, 0, 1'b0, 1'b0);
        check("reset sticky", 32'(sat_sticky), 0);
        check("reset hit_cnt", 32'(hit_cnt), 0);
        rst_n = 1'b1;

        // Clean 8-tap code, exact 3-edge latency
        do_hit(64'h0000_0000_0000_00FF, 1'b0);
        repeat (2) @(negedge clk);
        check("lat pre valid", 32'(valid_out), 0);
        @(negedge clk);
        lit("ff mode0", 1'b1, 8, 1'b0, 1'b0);
        check("ff hit_cnt", 32'(hit_cnt), 1);
        @(negedge clk);
        lit("ff hold", 1'b0, 8, 1'b0, 1'b0);

        // Single-tap bubble, back-to-back with mode toggled
        do_hit(64'h0000_0000_0000_00F7, 1'b0);
        do_hit(64'h0000_0000_0000_00F7, 1'b1);
        repeat (2) @(negedge clk);
        lit("f7 mode0", 1'b1, 8, 1'b0, 1'b0);
        @(negedge clk);
        lit("f7 mode1", 1'b1, 7, 1'b0, 1'b0);

        // Wide gap
        do_hit(64'h0000_0000_0000_F00F, 1'b0);
        repeat (3) @(negedge clk);
        lit("f00f", 1'b1, 16, 1'b1, 1'b0);

        // Saturation, then empty, then clear
        do_hit(ones_v, 1'b0);
        do_hit('0, 1'b0);
        repeat (2) @(negedge clk);
        lit("all ones", 1'b1, 64, 1'b0, 1'b1);
        check("all ones sticky", 32'(sat_sticky), 1);
        @(negedge clk);
        lit("all zeros", 1'b1, 0, 1'b0, 1'b0);
        check("zeros sticky", 32'(sat_sticky), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear sticky", 32'(sat_sticky), 0);
        check("clear hit_cnt", 32'(hit_cnt), 0);

        // Clear on the same edge as a saturated result
        do_hit(ones_v, 1'b1);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        lit("sat+clear", 1'b1, 64, 1'b0, 1'b1);
        check("sat+clear sticky", 32'(sat_sticky), 1);

        // Reset with samples in flight
        do_hit(64'h0000_0000_0000_000F, 1'b0);
        do_hit(64'h0000_0000_0000_003F, 1'b1);
        do_hit(ones_v, 1'b0);
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("in-reset valid", 32'(valid_out), 0);
        end
        lit("flush", 1'b0, 0, 1'b0, 1'b0);
        check("flush sticky", 32'(sat_sticky), 0);
        check("flush hit_cnt", 32'(hit_cnt), 0);
        rst_n = 1'b1;
        do_hit(64'h0000_0000_0000_0003, 1'b0);
        check("first edge hit_cnt", 32'(hit_cnt), 1);
        repeat (3) @(negedge clk);
        lit("post reset", 1'b1, 2, 1'b0, 1'b0);

        // Hit counter wrap and clear+hit
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        hit = 1'b1; thermo_in = '0; mode = 1'b0;
        repeat (65535) @(negedge clk);
        hit = 1'b0;
        check("preload hit_cnt", 32'(hit_cnt), 32'hFFFF);
        do_hit('0, 1'b0);
        check("wrap hit_cnt", 32'(hit_cnt), 0);
        clear = 1'b1; hit = 1'b1;
        @(negedge clk);
        clear = 1'b0; hit = 1'b0;
        check("clear+hit hit_cnt", 32'(hit_cnt), 1);

        repeat (6) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
